coproc_cmd_sequencer: RTL and testbench
=======================================

// Module: coproc_cmd_sequencer
// PURPOSE
//  Avalon-MM slave that sequences one coprocessor operation at a time for the HPS.
//  - HPS writes an instruction word; the block drives it to the coprocessor, pulses start and waits for done.
//  - On done it captures the 8-bit result into a small FIFO; the HPS reads results and status over the same slave.
//  - Sits between the HPS lightweight bridge and the coprocessor core, replacing raw instruction/data PIO polling.
// PARAMETERS
//  INSTR_W         32    width of the instruction word driven to the coprocessor
//  DATA_W          8     width of the coprocessor result
//  FIFO_DEPTH      4     result FIFO entries; power of 2, >=2
//  TIMEOUT_CYCLES  1024  max WAIT cycles before abort; >=2
// PORTS
//  clk            in   1        system clock
//  reset_n        in   1        asynchronous active-low reset
//  avs_address    in   2        register select
//  avs_write      in   1        register write strobe
//  avs_writedata  in   32       write data
//  avs_read       in   1        register read strobe
//  avs_readdata   out  32       registered read data
//  cop_instr      out  INSTR_W  instruction to coprocessor; held stable from ISSUE until back in IDLE
//  cop_start      out  1        one-cycle start pulse
//  cop_done       in   1        coprocessor completion, sampled only in WAIT
//  cop_data       in   DATA_W   result, valid in the cycle cop_done=1
//  irq            out  1        level interrupt to HPS
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE, FIFO empty, all sticky flags 0, irq_en 0.
//  Register map (address):
//  - 0 CMD: W = load instruction and launch; R = last launched instruction.
//  - 1 STATUS: R = {26'b0, rejected[5], overflow[4], timeout[3], full[2], valid[1], busy[0]}; W1C on bits 3..5.
//  - 2 RESULT: R = {zero-extended FIFO head}; pops the head. Empty -> reads 0, no state change.
//  - 3 CTRL: bit0 irq_en (R/W); bit1 abort (write-only pulse, reads 0).
//  Read timing:
//  - avs_readdata registered: value for avs_address appears the cycle after avs_read.
//  - Register updates every cycle; data for an unselected address is 0.
//  FSM states:
//  - IDLE: CMD write latches cop_instr -> ISSUE.
//  - ISSUE: cop_start=1 for exactly this cycle -> WAIT; clear timeout counter.
//  - WAIT: cop_done=1 -> push cop_data, go IDLE.
//    Counter reaches TIMEOUT_CYCLES-1 without done -> set timeout, go IDLE, no push.
//    abort -> IDLE, no push.
//  busy=1 in ISSUE and WAIT.
//  Edge cases:
//  - CMD write while busy: ignored, cop_instr unchanged, rejected set.
//  - cop_done outside WAIT: ignored.
//  - done and abort in the same WAIT cycle: done wins (result pushed).
//  - Push with FIFO full: result dropped, overflow set, contents unchanged.
//  - Push and pop in the same cycle: both occur, count unchanged. Legal when full; when empty, pop reads 0 and push lands.
//  - Pointers wrap modulo FIFO_DEPTH. Count width is clog2(FIFO_DEPTH)+1.
//  - W1C and sticky set in the same cycle: set wins.
//  irq = irq_en & (valid | timeout | overflow), registered (1-cycle lag).
//  Reset mid-operation: immediate return to reset state; the coprocessor must be reset by the same reset_n.
// STRUCTURE
//  - coproc_seq_defs.vh: register address localparams, STATUS bit indices, FSM state encodings.
//  - Sub-module coproc_result_fifo (DATA_W, FIFO_DEPTH): sync FIFO, push/pop/full/empty/count, show-ahead head.
//  - Top: FSM, timeout counter, sticky flags, read mux.
// TESTING
//  1 Basic op: write CMD=0x0000_00A5; start high exactly 1 cycle later with cop_instr=0xA5; done+data=0x3C after 5 cycles -> STATUS=0x2, RESULT reads 0x3C, then STATUS=0x0.
//  2 Timeout: start, never assert done -> after TIMEOUT_CYCLES in WAIT, STATUS=0x8, FIFO empty; write STATUS=0x8 -> STATUS=0x0.
//  3 Overflow: 5 ops with data 1..5, no reads -> STATUS bits full=1, overflow=1; RESULT reads 1,2,3,4 then 0.
//  4 Busy reject: write CMD=0x11, then CMD=0x22 during WAIT -> cop_instr stays 0x11, rejected=1, one result pushed.
//  5 Boundary: pop and done in the same cycle with FIFO full -> count stays 4, no overflow; abort during WAIT -> IDLE, no push.
//  6 IRQ and reset: irq_en=1, complete one op -> irq=1 until FIFO drained; reset_n low mid-WAIT -> all outputs 0, STATUS=0x0.

Source files
------------

// File: rtl/coproc_cmd_sequencer_pkg.sv
// Shared definitions for the coprocessor command sequencer: register map, STATUS bits, FSM states.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package coproc_cmd_sequencer_pkg;

   // Avalon register addresses
   localparam logic [1:0] ADDR_CMD    = 2'd0;
   localparam logic [1:0] ADDR_STATUS = 2'd1;
   localparam logic [1:0] ADDR_RESULT = 2'd2;
   localparam logic [1:0] ADDR_CTRL   = 2'd3;

   // STATUS bit positions; bits 3..5 are sticky and write-1-to-clear
   localparam int ST_BUSY     = 0;
   localparam int ST_VALID    = 1;
   localparam int ST_FULL     = 2;
   localparam int ST_TIMEOUT  = 3;
   localparam int ST_OVERFLOW = 4;
   localparam int ST_REJECTED = 5;

   // CTRL bit positions
   localparam int CTRL_IRQ_EN = 0;
   localparam int CTRL_ABORT  = 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2
   } seq_state_t;

endpackage

// File: rtl/coproc_cmd_sequencer_if.sv
// Bus bundle between the HPS Avalon-MM slave port, the sequencer and the coprocessor core.
// Latency: n/a (wiring only).
// Backpressure: none; Avalon side has no waitrequest, coprocessor side is start/done.
interface coproc_cmd_sequencer_if #(
   parameter int INSTR_W = 32,
   parameter int DATA_W  = 8
);
   logic [1:0]         avs_address;
   logic               avs_write;
   logic [31:0]        avs_writedata;
   logic               avs_read;
   logic [31:0]        avs_readdata;
   logic [INSTR_W-1:0] cop_instr;
   logic               cop_start;
   logic               cop_done;
   logic [DATA_W-1:0]  cop_data;
   logic               irq;

   // Sequencer view
   modport slave (
      input  avs_address, avs_write, avs_writedata, avs_read, cop_done, cop_data,
      output avs_readdata, cop_instr, cop_start, irq
   );

   // HPS + coprocessor view (driver side)
   modport master (
      output avs_address, avs_write, avs_writedata, avs_read, cop_done, cop_data,
      input  avs_readdata, cop_instr, cop_start, irq
   );
endinterface

// File: rtl/coproc_result_fifo.sv
// Synchronous show-ahead FIFO holding coprocessor results.
// Latency: push visible at head the cycle after the write; head valid combinationally while not empty.
// Backpressure: push while full is dropped unless a pop happens in the same cycle; pop while empty is ignored.
module coproc_result_fifo #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 4
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       push,
   input  logic [DATA_W-1:0]          push_data,
   input  logic                       pop,
   output logic [DATA_W-1:0]          head,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic              do_push;
   logic              do_pop;

   // A pop frees a slot in the same cycle, so a full FIFO can still accept a push alongside it
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign head    = empty ? '0 : mem[rd_ptr];

   // Storage write; contents need no reset because head is masked while empty
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

   // Pointer and occupancy bookkeeping; pointers wrap naturally at the power-of-2 depth
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end
endmodule

// File: rtl/coproc_cmd_sequencer.sv
// Avalon-MM slave that launches one coprocessor instruction at a time and queues its 8-bit results.
// Latency: cop_start one cycle after the CMD write; read data one cycle after avs_read; irq lags flags by one cycle.
// Backpressure: CMD writes while busy are dropped (rejected flag); results arriving with a full FIFO are dropped (overflow flag).
module coproc_cmd_sequencer #(
   parameter int INSTR_W        = 32,
   parameter int DATA_W         = 8,
   parameter int FIFO_DEPTH     = 4,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input logic                   clk,
   input logic                   reset_n,
   coproc_cmd_sequencer_if.slave bus
);
   import coproc_cmd_sequencer_pkg::*;

   localparam int TMO_W = $clog2(TIMEOUT_CYCLES);
   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

   seq_state_t        state;
   logic [TMO_W-1:0]  tmo_cnt;
   logic              flag_timeout;
   logic              flag_overflow;
   logic              flag_rejected;
   logic              irq_en;
   logic              fifo_full;
   logic              fifo_empty;
   logic [CNT_W-1:0]  fifo_count;
   logic [DATA_W-1:0] fifo_head;
   logic              cmd_wr;
   logic              status_wr;
   logic              ctrl_wr;
   logic              result_rd;
   logic              abort_req;
   logic              busy;
   logic              in_wait;
   logic              push_req;
   logic              pop_req;
   logic              timeout_hit;
   logic              result_valid;
   logic [31:0]       status_word;

   assign cmd_wr       = bus.avs_write && (bus.avs_address == ADDR_CMD);
   assign status_wr    = bus.avs_write && (bus.avs_address == ADDR_STATUS);
   assign ctrl_wr      = bus.avs_write && (bus.avs_address == ADDR_CTRL);
   assign result_rd    = bus.avs_read  && (bus.avs_address == ADDR_RESULT);
   assign abort_req    = ctrl_wr && bus.avs_writedata[CTRL_ABORT];
   assign busy         = (state != S_IDLE);
   assign in_wait      = (state == S_WAIT);
   // done has priority over abort and over the last timeout cycle
   assign push_req     = in_wait && bus.cop_done;
   assign pop_req      = result_rd && !fifo_empty;
   assign timeout_hit  = in_wait && !bus.cop_done && !abort_req && (tmo_cnt == TMO_LAST);
   assign result_valid = (fifo_count != '0);
   assign status_word  = {26'b0, flag_rejected, flag_overflow, flag_timeout,
                          fifo_full, result_valid, busy};

   coproc_result_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (FIFO_DEPTH)
   ) u_result_fifo (
      .clk       (clk),
      .reset_n   (reset_n),
      .push      (push_req),
      .push_data (bus.cop_data),
      .pop       (pop_req),
      .head      (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   // Sequencing FSM: latch instruction, pulse start for the ISSUE cycle, then wait for done/abort/timeout
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state         <= S_IDLE;
         tmo_cnt       <= '0;
         bus.cop_instr <= '0;
         bus.cop_start <= 1'b0;
      end else begin
         bus.cop_start <= 1'b0;
         case (state)
            S_IDLE: begin
               if (cmd_wr) begin
                  bus.cop_instr <= bus.avs_writedata[INSTR_W-1:0];
                  bus.cop_start <= 1'b1;
                  state         <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               tmo_cnt <= '0;
               state   <= S_WAIT;
            end
            S_WAIT: begin
               if (bus.cop_done || abort_req || (tmo_cnt == TMO_LAST)) state <= S_IDLE;
               else                                                  tmo_cnt <= tmo_cnt + TMO_W'(1);
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // Sticky flags (a set in the same cycle as a W1C wins), irq enable and the registered irq level
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         flag_timeout  <= 1'b0;
         flag_overflow <= 1'b0;
         flag_rejected <= 1'b0;
         irq_en        <= 1'b0;
         bus.irq       <= 1'b0;
      end else begin
         flag_timeout  <= timeout_hit |
                          (flag_timeout & ~(status_wr & bus.avs_writedata[ST_TIMEOUT]));
         flag_overflow <= (push_req & fifo_full & ~pop_req) |
                          (flag_overflow & ~(status_wr & bus.avs_writedata[ST_OVERFLOW]));
         flag_rejected <= (cmd_wr & busy) |
                          (flag_rejected & ~(status_wr & bus.avs_writedata[ST_REJECTED]));
         if (ctrl_wr) irq_en <= bus.avs_writedata[CTRL_IRQ_EN];
         bus.irq <= irq_en & (result_valid | flag_timeout | flag_overflow);
      end
   end

   // Registered read mux; bus reads back 0 when nothing is being read
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         bus.avs_readdata <= '0;
      end else if (bus.avs_read) begin
         case (bus.avs_address)
            ADDR_CMD:    bus.avs_readdata <= 32'(bus.cop_instr);
            ADDR_STATUS: bus.avs_readdata <= status_word;
            ADDR_RESULT: bus.avs_readdata <= 32'(fifo_head);
            default:     bus.avs_readdata <= {31'b0, irq_en};
         endcase
      end else begin
         bus.avs_readdata <= '0;
      end
   end
endmodule

// File: tb/tb_coproc_cmd_sequencer.sv
// Self-checking bench for coproc_cmd_sequencer: directed scenarios plus randomized operations.
// Latency: checks start one cycle after CMD write and read data one cycle after avs_read.
// Backpressure: exercises busy rejects, FIFO overflow and simultaneous push/pop.
module tb_coproc_cmd_sequencer;
   localparam int T     = 32;
   localparam int DEPTH = 4;
   localparam logic [1:0] A_CMD = 2'd0, A_STATUS = 2'd1, A_RESULT = 2'd2, A_CTRL = 2'd3;

   logic clk;
   logic reset_n;
   int   n_checks;
   int   n_errors;

   // Reference model: results queue, sticky flags, irq enable
   logic [7:0] q[$];
   bit         m_to, m_ov, m_rj, m_irq_en;

   coproc_cmd_sequencer_if #(.INSTR_W(32), .DATA_W(8)) bus ();

   coproc_cmd_sequencer #(
      .INSTR_W(32), .DATA_W(8), .FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(T)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Watchdog so the run always ends
   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", n_checks, n_errors);
      $fatal(1, "watchdog expired");
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
      bus.avs_address   = a;
      bus.avs_writedata = d;
      bus.avs_write     = 1'b1;
      tick();
      bus.avs_write     = 1'b0;
   endtask

   task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
      bus.avs_address = a;
      bus.avs_read    = 1'b1;
      tick();
      bus.avs_read    = 1'b0;
      d = bus.avs_readdata;
   endtask

   function automatic logic [31:0] exp_status(input bit busy);
      return {26'b0, m_rj, m_ov, m_to, (q.size() == DEPTH), (q.size() != 0), busy};
   endfunction

   task automatic m_push(input logic [7:0] d);
      if (q.size() < DEPTH) q.push_back(d);
      else                  m_ov = 1'b1;
   endtask

   task automatic m_clear(input logic [31:0] d);
      if (d[3]) m_to = 1'b0;
      if (d[4]) m_ov = 1'b0;
      if (d[5]) m_rj = 1'b0;
   endtask

   task automatic check_status(input string tag, input bit busy);
      logic [31:0] d;
      bus_read(A_STATUS, d);
      check_eq(tag, d, exp_status(busy));
   endtask

   task automatic check_result(input string tag);
      logic [31:0] d;
      logic [31:0] e;
      if (q.size() != 0) e = 32'(q.pop_front());
      else               e = 32'h0;
      bus_read(A_RESULT, d);
      check_eq(tag, d, e);
   endtask

   // Write CMD in IDLE; returns with the DUT in WAIT and no WAIT cycle consumed yet
   task automatic launch(input logic [31:0] instr);
      bus_write(A_CMD, instr);
      check_eq("start_pulse", 32'(bus.cop_start), 32'h1);
      check_eq("cop_instr", bus.cop_instr, instr);
      tick();
      check_eq("start_single", 32'(bus.cop_start), 32'h0);
   endtask

   task automatic complete(input int lat, input logic [7:0] d);
      repeat (lat) tick();
      bus.cop_done = 1'b1;
      bus.cop_data = d;
      tick();
      bus.cop_done = 1'b0;
      m_push(d);
   endtask

   task automatic model_reset();
      q.delete();
      m_to = 0; m_ov = 0; m_rj = 0; m_irq_en = 0;
   endtask

   initial begin
      logic [31:0] d;
      logic [31:0] instr;
      int          kind;
      n_checks = 0;
      n_errors = 0;
      model_reset();
      reset_n           = 1'b0;
      bus.avs_address   = '0;
      bus.avs_write     = 1'b0;
      bus.avs_writedata = '0;
      bus.avs_read      = 1'b0;
      bus.cop_done      = 1'b0;
      bus.cop_data      = '0;
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_start", 32'(bus.cop_start), 32'h0);
      check_eq("rst_instr", bus.cop_instr, 32'h0);
      check_eq("rst_irq", 32'(bus.irq), 32'h0);
      check_eq("rst_rdata", bus.avs_readdata, 32'h0);
      reset_n = 1'b1;
      tick();
      check_status("rst_status", 0);

      // Basic operation
      launch(32'h0000_00A5);
      complete(4, 8'h3C);
      bus_read(A_STATUS, d); check_eq("basic_status", d, 32'h2);
      check_result("basic_result");
      bus_read(A_STATUS, d); check_eq("basic_status_after", d, 32'h0);
      bus_read(A_CMD, d);    check_eq("basic_cmd_rb", d, 32'hA5);

      // Timeout: busy through the last WAIT cycle, then timeout set
      launch(32'h77);
      repeat (T - 1) tick();
      bus_read(A_STATUS, d); check_eq("tmo_last_cycle_busy", d, 32'h1);
      m_to = 1'b1;
      bus_read(A_STATUS, d); check_eq("tmo_status", d, 32'h8);
      check_result("tmo_fifo_empty");
      bus_write(A_STATUS, 32'h8); m_clear(32'h8);
      bus_read(A_STATUS, d); check_eq("tmo_w1c", d, 32'h0);

      // Overflow: five results, no reads
      for (int i = 1; i <= 5; i++) begin
         launch(32'(i));
         complete(2, 8'(i));
      end
      bus_read(A_STATUS, d); check_eq("ovf_status", d, 32'h16);
      for (int i = 0; i < 5; i++) check_result("ovf_drain");
      bus_write(A_STATUS, 32'h10); m_clear(32'h10);
      check_status("ovf_w1c", 0);

      // Busy reject
      launch(32'h11);
      tick();
      bus_write(A_CMD, 32'h22); m_rj = 1'b1;
      check_eq("rej_instr_held", bus.cop_instr, 32'h11);
      complete(1, 8'h55);
      bus_read(A_STATUS, d); check_eq("rej_status", d, 32'h22);
      bus_read(A_CMD, d);    check_eq("rej_cmd_rb", d, 32'h11);
      check_result("rej_result");
      bus_write(A_STATUS, 32'h20); m_clear(32'h20);

      // Pop and done together with FIFO full
      for (int i = 0; i < DEPTH; i++) begin
         launch(32'h100 + 32'(i));
         complete(1, 8'hA0 + 8'(i));
      end
      launch(32'h200);
      tick();
      bus.avs_address = A_RESULT; bus.avs_read = 1'b1;
      bus.cop_done = 1'b1; bus.cop_data = 8'hEE;
      tick();
      bus.avs_read = 1'b0; bus.cop_done = 1'b0;
      check_eq("full_popush_data", bus.avs_readdata, 32'(q.pop_front()));
      q.push_back(8'hEE);
      bus_read(A_STATUS, d); check_eq("full_popush_status", d, 32'h6);
      for (int i = 0; i < DEPTH; i++) check_result("full_popush_drain");

      // Pop and done together with FIFO empty
      launch(32'h300);
      bus.avs_address = A_RESULT; bus.avs_read = 1'b1;
      bus.cop_done = 1'b1; bus.cop_data = 8'h5A;
      tick();
      bus.avs_read = 1'b0; bus.cop_done = 1'b0;
      check_eq("empty_popush_data", bus.avs_readdata, 32'h0);
      q.push_back(8'h5A);
      check_status("empty_popush_status", 0);
      check_result("empty_popush_result");

      // Abort during WAIT
      launch(32'h33);
      repeat (2) tick();
      bus_write(A_CTRL, 32'h2);
      bus_read(A_STATUS, d); check_eq("abort_status", d, 32'h0);
      check_result("abort_no_push");

      // IRQ
      bus_write(A_CTRL, 32'h1); m_irq_en = 1'b1;
      tick();
      check_eq("irq_idle", 32'(bus.irq), 32'h0);
      launch(32'h44);
      complete(2, 8'h99);
      repeat (2) tick();
      check_eq("irq_set", 32'(bus.irq), 32'h1);
      check_result("irq_result");
      repeat (2) tick();
      check_eq("irq_drained", 32'(bus.irq), 32'h0);

      // Reset in the middle of WAIT with a result pending and irq high
      launch(32'h45);
      complete(1, 8'h46);
      launch(32'h5A);
      repeat (2) tick();
      check_eq("irq_pre_reset", 32'(bus.irq), 32'h1);
      reset_n = 1'b0;
      #1;
      model_reset();
      check_eq("mid_rst_start", 32'(bus.cop_start), 32'h0);
      check_eq("mid_rst_instr", bus.cop_instr, 32'h0);
      check_eq("mid_rst_irq", 32'(bus.irq), 32'h0);
      tick();
      reset_n = 1'b1;
      tick();
      bus_read(A_STATUS, d); check_eq("mid_rst_status", d, 32'h0);
      bus_read(A_CTRL, d);   check_eq("mid_rst_ctrl", d, 32'h0);

      // Randomized operations against the model
      for (int it = 0; it < 60; it++) begin
         instr = $urandom;
         kind  = int'($urandom_range(0, 9));
         launch(instr);
         if (kind == 0) begin
            repeat (T) tick();
            m_to = 1'b1;
         end else if (kind == 1) begin
            repeat ($urandom_range(0, 5)) tick();
            bus_write(A_CTRL, {30'b0, 1'b1, m_irq_en});
         end else if (kind == 2) begin
            tick();
            bus_write(A_CMD, $urandom); m_rj = 1'b1;
            check_eq("rnd_rej_instr", bus.cop_instr, instr);
            complete(int'($urandom_range(0, 6)), 8'($urandom));
         end else begin
            complete(int'($urandom_range(0, 6)), 8'($urandom));
         end
         check_status("rnd_status", 0);
         if ($urandom_range(0, 1) == 0) check_result("rnd_result");
         if ($urandom_range(0, 3) == 0) begin
            d = {26'b0, 3'($urandom), 3'b0};
            bus_write(A_STATUS, d);
            m_clear(d);
         end
         if ($urandom_range(0, 3) == 0) begin
            bus_read(A_CMD, d); check_eq("rnd_cmd_rb", d, instr);
         end
         if ($urandom_range(0, 7) == 0) begin
            m_irq_en = 1'($urandom);
            bus_write(A_CTRL, {31'b0, m_irq_en});
         end
         repeat (2) tick();
         check_eq("rnd_irq", 32'(bus.irq),
                  32'(m_irq_en & ((q.size() != 0) | m_to | m_ov)));
      end
      while (q.size() != 0) check_result("rnd_drain");
      check_result("rnd_drain_empty");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
